scan_select_ctrl: RTL and testbench

Upstream control stage for the 4-to-1 4-bit selector in the display path. It latches four 4-bit digit values and drives them as stable selector channel inputs. It generates the 2-bit scan select (oS1,oS0) and matching active-low digit enables from a programmable prescaler. Disabled digits are skipped, so the downstream selector only ever presents enabled digits.

---
 rtl/scan_select_ctrl.sv | 114 +++++++++++
 tb/tb_scan_select_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_select_ctrl.sv
// Display scan controller: latches four digit values for the downstream 4:1 selector
// and steps a skip-disabled scan index on a programmable prescaler tick.
module scan_select_ctrl #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned DIV_MAX   = 49999
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iLoad,
  input  logic [3:0] iD0,
  input  logic [3:0] iD1,
  input  logic [3:0] iD2,
  input  logic [3:0] iD3,
  input  logic [3:0] iEnMask,
  input  logic       iHold,
  output logic [3:0] oC0,
  output logic [3:0] oC1,
  output logic [3:0] oC2,
  output logic [3:0] oC3,
  output logic       oS1,
  output logic       oS0,
  output logic [3:0] oAn,
  output logic       oTick
);

  localparam logic [DIV_WIDTH-1:0] DivMaxC = DIV_WIDTH'(DIV_MAX);
  localparam logic [DIV_WIDTH-1:0] OneC    = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tick_q, tick_d;
  logic [1:0]           idx_q, idx_d;
  logic [3:0]           an_q, an_d;
  logic [3:0]           c0_q, c1_q, c2_q, c3_q;
  logic                 wrap_s;

  assign wrap_s = !iHold && (cnt_q == DivMaxC);

  // Prescaler next count and tick pulse
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (iHold) begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
    end else if (wrap_s) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + OneC;
      tick_d = 1'b0;
    end
  end

  // Next scan index (first enabled digit after the current one) and digit enables
  always_comb begin
    logic       found;
    logic [1:0] cand;
    idx_d = idx_q;
    found = 1'b0;
    cand  = 2'b00;
    if (wrap_s) begin
      // i == 4 wraps back onto the current digit, so a lone enabled digit is kept
      for (int i = 1; i <= 4; i++) begin
        cand = idx_q + 2'(i);
        if (!found && iEnMask[cand]) begin
          idx_d = cand;
          found = 1'b1;
        end else begin
          found = found;
        end
      end
    end else begin
      idx_d = idx_q;
    end
    for (int k = 0; k < 4; k++) begin
      an_d[k] = !((idx_d == 2'(k)) && iEnMask[k]);
    end
  end

  // State registers
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      idx_q  <= 2'b00;
      an_q   <= 4'b1111;
      c0_q   <= 4'h0;
      c1_q   <= 4'h0;
      c2_q   <= 4'h0;
      c3_q   <= 4'h0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      if (iLoad) begin
        c0_q <= iD0;
        c1_q <= iD1;
        c2_q <= iD2;
        c3_q <= iD3;
      end
    end
  end

  assign oC0   = c0_q;
  assign oC1   = c1_q;
  assign oC2   = c2_q;
  assign oC3   = c3_q;
  assign oS1   = idx_q[1];
  assign oS0   = idx_q[0];
  assign oAn   = an_q;
  assign oTick = tick_q;

endmodule

// File: tb/tb_scan_select_ctrl.sv
// Directed bench for scan_select_ctrl with a 4-clock scan tick (DIV_MAX=3).
module tb_scan_select_ctrl;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iLoad = 1'b0;
  logic [3:0] iD0 = 4'h0, iD1 = 4'h0, iD2 = 4'h0, iD3 = 4'h0;
  logic [3:0] iEnMask = 4'b1111;
  logic       iHold = 1'b0;
  logic [3:0] oC0, oC1, oC2, oC3;
  logic       oS1, oS0;
  logic [3:0] oAn;
  logic       oTick;

  int n_cmp = 0;
  int n_err = 0;

  scan_select_ctrl #(.DIV_WIDTH(4), .DIV_MAX(3)) dut (
    .iClk(iClk), .iRst(iRst), .iLoad(iLoad),
    .iD0(iD0), .iD1(iD1), .iD2(iD2), .iD3(iD3),
    .iEnMask(iEnMask), .iHold(iHold),
    .oC0(oC0), .oC1(oC1), .oC2(oC2), .oC3(oC3),
    .oS1(oS1), .oS0(oS0), .oAn(oAn), .oTick(oTick)
  );

  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge iClk);
    iRst = 1'b0;
    iLoad = 1'b1; iD0 = 4'h9; iD1 = 4'h8; iD2 = 4'h7; iD3 = 4'h6;
    step();
    iLoad = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2 iRst = 1'b1;
    #1;
    n_cmp++;
    if ({oS1, oS0} !== 2'b00 || oAn !== 4'b1111 || oTick !== 1'b0 ||
        {oC0, oC1, oC2, oC3} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_async: S=%b An=%b Tick=%b C=%h%h%h%h want S=00 An=1111 Tick=0 C=0000",
               {oS1, oS0}, oAn, oTick, oC0, oC1, oC2, oC3);
    end
    @(negedge iClk);
    iRst = 1'b0;
    step();
    n_cmp++;
    if ({oS1, oS0} !== 2'b00 || oAn !== 4'b1110 || oTick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_edge: S=%b An=%b Tick=%b want S=00 An=1110 Tick=0",
               {oS1, oS0}, oAn, oTick);
    end
  endtask

  task automatic test_free_run();
    logic [1:0] eidx;
    logic [3:0] ean;
    iEnMask = 4'b1111;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      step();
      eidx = 2'((e / 4) % 4);
      ean  = 4'b1111 ^ (4'b0001 << eidx);
      n_cmp++;
      if ({oS1, oS0} !== eidx || oAn !== ean || oTick !== (e % 4 == 0)) begin
        n_err++;
        $display("FAIL free_run e=%0d: S=%b An=%b Tick=%b want S=%b An=%b Tick=%b",
                 e, {oS1, oS0}, oAn, oTick, eidx, ean, (e % 4 == 0));
      end
    end
  endtask

  task automatic test_mask_0101();
    logic [1:0] eidx;
    logic [3:0] ean;
    iEnMask = 4'b0101;
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      step();
      eidx = ((e / 4) % 2 == 1) ? 2'b10 : 2'b00;
      ean  = (eidx == 2'b10) ? 4'b1011 : 4'b1110;
      n_cmp++;
      if ({oS1, oS0} !== eidx || oAn !== ean) begin
        n_err++;
        $display("FAIL mask_0101 e=%0d: S=%b An=%b want S=%b An=%b",
                 e, {oS1, oS0}, oAn, eidx, ean);
      end
    end
  endtask

  task automatic test_empty_mask();
    iEnMask = 4'b1111;
    do_reset();
    for (int e = 1; e <= 4; e++) step();
    n_cmp++;
    if ({oS1, oS0} !== 2'b01 || oAn !== 4'b1101) begin
      n_err++;
      $display("FAIL empty_setup: S=%b An=%b want S=01 An=1101", {oS1, oS0}, oAn);
    end
    iEnMask = 4'b0000;
    for (int e = 5; e <= 12; e++) begin
      step();
      n_cmp++;
      if ({oS1, oS0} !== 2'b01 || oAn !== 4'b1111 || oTick !== (e % 4 == 0)) begin
        n_err++;
        $display("FAIL empty_mask e=%0d: S=%b An=%b Tick=%b want S=01 An=1111 Tick=%b",
                 e, {oS1, oS0}, oAn, oTick, (e % 4 == 0));
      end
    end
    iEnMask = 4'b1000;
    for (int e = 13; e <= 15; e++) begin
      step();
      n_cmp++;
      if ({oS1, oS0} !== 2'b01 || oAn !== 4'b1111) begin
        n_err++;
        $display("FAIL mask_1000_wait e=%0d: S=%b An=%b want S=01 An=1111",
                 e, {oS1, oS0}, oAn);
      end
    end
    step();
    n_cmp++;
    if ({oS1, oS0} !== 2'b11 || oAn !== 4'b0111 || oTick !== 1'b1) begin
      n_err++;
      $display("FAIL mask_1000_tick: S=%b An=%b Tick=%b want S=11 An=0111 Tick=1",
               {oS1, oS0}, oAn, oTick);
    end
  endtask

  task automatic test_load_tick();
    iEnMask = 4'b1111;
    do_reset();
    for (int e = 1; e <= 3; e++) step();
    iLoad = 1'b1; iD0 = 4'hA; iD1 = 4'h5; iD2 = 4'h3; iD3 = 4'hF;
    step();
    iLoad = 1'b0;
    n_cmp++;
    if ({oC0, oC1, oC2, oC3} !== 16'hA53F || {oS1, oS0} !== 2'b01 || oTick !== 1'b1) begin
      n_err++;
      $display("FAIL load_tick: C=%h%h%h%h S=%b Tick=%b want C=A53F S=01 Tick=1",
               oC0, oC1, oC2, oC3, {oS1, oS0}, oTick);
    end
    iD0 = 4'h1; iD1 = 4'h2; iD2 = 4'h4; iD3 = 4'h8;
    for (int e = 0; e < 3; e++) step();
    n_cmp++;
    if ({oC0, oC1, oC2, oC3} !== 16'hA53F) begin
      n_err++;
      $display("FAIL load_hold: C=%h%h%h%h want C=A53F", oC0, oC1, oC2, oC3);
    end
  endtask

  task automatic test_hold();
    logic [3:0] ean;
    iEnMask = 4'b1111;
    do_reset();
    step();
    step();
    iHold = 1'b1;
    for (int h = 1; h <= 10; h++) begin
      step();
      ean = (h >= 5 && h <= 7) ? 4'b1111 : 4'b1110;
      n_cmp++;
      if ({oS1, oS0} !== 2'b00 || oAn !== ean || oTick !== 1'b0) begin
        n_err++;
        $display("FAIL hold h=%0d: S=%b An=%b Tick=%b want S=00 An=%b Tick=0",
                 h, {oS1, oS0}, oAn, oTick, ean);
      end
      if (h == 4) iEnMask = 4'b1110;
      else if (h == 7) iEnMask = 4'b1111;
    end
    iHold = 1'b0;
    step();
    n_cmp++;
    if ({oS1, oS0} !== 2'b00 || oTick !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release_1: S=%b Tick=%b want S=00 Tick=0", {oS1, oS0}, oTick);
    end
    step();
    n_cmp++;
    if ({oS1, oS0} !== 2'b01 || oAn !== 4'b1101 || oTick !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release_2: S=%b An=%b Tick=%b want S=01 An=1101 Tick=1",
               {oS1, oS0}, oAn, oTick);
    end
    iHold = 1'b1;
    step();
    #2 iRst = 1'b1;
    #1;
    n_cmp++;
    if ({oS1, oS0} !== 2'b00 || oAn !== 4'b1111 || oTick !== 1'b0 ||
        {oC0, oC1, oC2, oC3} !== 16'h0000) begin
      n_err++;
      $display("FAIL hold_reset: S=%b An=%b Tick=%b C=%h%h%h%h want S=00 An=1111 Tick=0 C=0000",
               {oS1, oS0}, oAn, oTick, oC0, oC1, oC2, oC3);
    end
    @(negedge iClk);
    iRst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      n_cmp++;
      if ({oS1, oS0} !== 2'b00 || oAn !== 4'b1110 || oTick !== 1'b0) begin
        n_err++;
        $display("FAIL hold_after_reset e=%0d: S=%b An=%b Tick=%b want S=00 An=1110 Tick=0",
                 e, {oS1, oS0}, oAn, oTick);
      end
    end
    iHold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_mask_0101();
    test_empty_mask();
    test_load_tick();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
